// File: rtl/eth_frame_loop_pkg.sv
// Shared definitions for the frame-loop log reader: header layout, FSM states and word math.
package eth_frame_loop_pkg;

    localparam int unsigned C_HDR_BITS      = 128;
    localparam int unsigned CNT_W           = 17;

    localparam int unsigned HDR_MSG_ID_LSB  = 0;
    localparam int unsigned HDR_SIZE_LSB    = 16;
    localparam int unsigned HDR_MATCHED_LSB = 32;
    localparam int unsigned HDR_TRUNC_BIT   = 63;
    localparam int unsigned HDR_TS_LSB      = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DRAIN
    } state_t;

    // Number of b-byte words needed to hold size bytes (ceiling division).
    function automatic logic [CNT_W-1:0] words_for_bytes(input logic [CNT_W-1:0] size,
                                                         input int unsigned b);
        logic [31:0] words;
        words = (32'(size) + b - 32'd1) / b;
        return CNT_W'(words);
    endfunction

endpackage

// File: rtl/eth_frame_loop_word_mask.sv
// Zeroes the bytes of a packed word at and above byte index nbytes; nbytes == 0 keeps every byte.
module eth_frame_loop_word_mask #(
    parameter int unsigned W  = 64,
    parameter int unsigned LB = $clog2(W / 8)
) (
    input  logic [W-1:0]  data,
    input  logic [LB-1:0] nbytes,
    output logic [W-1:0]  data_c
);

    localparam int unsigned B = W / 8;

    always_comb begin
        data_c = '0;
        for (int i = 0; i < B; i++) begin
            data_c[i*8 +: 8] = (nbytes == '0 || LB'(i) < nbytes) ? data[i*8 +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/eth_frame_loop_log_reader.sv
// Pops one ctl entry plus its frame words and emits a header+payload log message on one AXI-Stream,
// optionally truncating the payload while still draining the frame FIFO.
module eth_frame_loop_log_reader
    import eth_frame_loop_pkg::*;
#(
    parameter int unsigned C_NUM_SCRIPTS      = 4,
    parameter int unsigned C_NUM_SCRIPTS_CEIL = 8,
    parameter int unsigned C_AXIS_LOG_WIDTH   = 64,
    parameter logic [15:0] C_MSG_ID           = 16'h0100
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           srst,
    input  logic                           enable,
    input  logic [15:0]                    max_size,
    output logic [31:0]                    frames_logged,
    output logic [31:0]                    frames_truncated,
    input  logic [C_NUM_SCRIPTS_CEIL+79:0] s_axis_ctl_tdata,
    input  logic                           s_axis_ctl_tvalid,
    output logic                           s_axis_ctl_tready,
    input  logic [C_AXIS_LOG_WIDTH-1:0]    s_axis_frame_tdata,
    input  logic                           s_axis_frame_tvalid,
    output logic                           s_axis_frame_tready,
    output logic [C_AXIS_LOG_WIDTH-1:0]    m_axis_log_tdata,
    output logic                           m_axis_log_tlast,
    output logic                           m_axis_log_tvalid,
    input  logic                           m_axis_log_tready
);

    localparam int unsigned W         = C_AXIS_LOG_WIDTH;
    localparam int unsigned B         = W / 8;
    localparam int unsigned LB        = $clog2(B);
    localparam int unsigned HDR_WORDS = C_HDR_BITS / W;

    if (C_NUM_SCRIPTS > C_NUM_SCRIPTS_CEIL || C_NUM_SCRIPTS_CEIL > 16 ||
        (W != 32 && W != 64 && W != 128)) begin : g_bad_cfg
        $error("eth_frame_loop_log_reader: unsupported parameter combination");
    end

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              word_cnt_q, word_cnt_d;
    logic [C_NUM_SCRIPTS_CEIL-1:0] matched_q, matched_d;
    logic [15:0]                   size_q, size_d;
    logic [63:0]                   ts_q, ts_d;
    logic [CNT_W-1:0]              out_words_q, out_words_d;
    logic [CNT_W-1:0]              drain_words_q, drain_words_d;
    logic                          trunc_q, trunc_d;
    logic [LB-1:0]                 eff_lo_q, eff_lo_d;
    logic [W-1:0]                  m_tdata_q, m_tdata_d;
    logic                          m_tlast_q, m_tlast_d;
    logic                          m_tvalid_q, m_tvalid_d;
    logic [31:0]                   logged_q, trunc_cnt_q;

    logic                          ctl_tready_c, frame_tready_c, done_c, out_free_c, last_c;
    logic [15:0]                   ctl_size_c;
    logic                          ctl_trunc_c;
    logic [CNT_W-1:0]              eff_c, total_c, out_c;
    logic [C_HDR_BITS-1:0]         hdr_c, hdr_shift_c;
    logic [W-1:0]                  masked_c;

    // Header image built from the latched ctl entry, selected one word at a time.
    always_comb begin
        hdr_c                           = '0;
        hdr_c[HDR_MSG_ID_LSB +: 16]     = C_MSG_ID;
        hdr_c[HDR_SIZE_LSB +: 16]       = size_q;
        hdr_c[HDR_MATCHED_LSB +: 16]    = 16'(matched_q);
        hdr_c[HDR_TRUNC_BIT]            = trunc_q;
        hdr_c[HDR_TS_LSB +: 64]         = ts_q;
        hdr_shift_c                     = hdr_c >> (8'(word_cnt_q[2:0]) * 8'(W));
    end

    assign ctl_size_c  = s_axis_ctl_tdata[79:64];
    assign ctl_trunc_c = (max_size != 16'd0) && (ctl_size_c > max_size);
    assign eff_c       = ctl_trunc_c ? CNT_W'(max_size) : CNT_W'(ctl_size_c);
    assign total_c     = words_for_bytes(CNT_W'(ctl_size_c), B);
    assign out_c       = words_for_bytes(eff_c, B);
    assign out_free_c  = ~m_tvalid_q | m_axis_log_tready;
    assign last_c      = (word_cnt_q + CNT_W'(1)) == out_words_q;

    eth_frame_loop_word_mask #(.W(W), .LB(LB)) u_mask (
        .data   (s_axis_frame_tdata),
        .nbytes (last_c ? eff_lo_q : '0),
        .data_c (masked_c)
    );

    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        matched_d      = matched_q;
        size_d         = size_q;
        ts_d           = ts_q;
        out_words_d    = out_words_q;
        drain_words_d  = drain_words_q;
        trunc_d        = trunc_q;
        eff_lo_d       = eff_lo_q;
        m_tdata_d      = m_tdata_q;
        m_tlast_d      = m_tlast_q;
        m_tvalid_d     = m_tvalid_q & ~m_axis_log_tready;
        ctl_tready_c   = 1'b0;
        frame_tready_c = 1'b0;
        done_c         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rst_n && enable && s_axis_ctl_tvalid) begin
                    ctl_tready_c  = 1'b1;
                    ts_d          = s_axis_ctl_tdata[63:0];
                    size_d        = ctl_size_c;
                    matched_d     = s_axis_ctl_tdata[C_NUM_SCRIPTS_CEIL+79:80];
                    trunc_d       = ctl_trunc_c;
                    eff_lo_d      = eff_c[LB-1:0];
                    out_words_d   = out_c;
                    drain_words_d = total_c - out_c;
                    word_cnt_d    = '0;
                    state_d       = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (out_free_c) begin
                    if (word_cnt_q < CNT_W'(HDR_WORDS)) begin
                        m_tdata_d  = hdr_shift_c[W-1:0];
                        m_tvalid_d = 1'b1;
                        m_tlast_d  = (word_cnt_q == CNT_W'(HDR_WORDS - 1)) && (out_words_q == '0);
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (word_cnt_q == CNT_W'(HDR_WORDS - 1) && out_words_q != '0) begin
                            word_cnt_d = '0;
                            state_d    = ST_PAYLOAD;
                        end
                    end else begin
                        // Header-only message: leave once its tlast word has been taken.
                        word_cnt_d = '0;
                        state_d    = (drain_words_q != '0) ? ST_DRAIN : ST_IDLE;
                        done_c     = (drain_words_q == '0);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (word_cnt_q == out_words_q) begin
                    if (out_free_c) begin
                        state_d = ST_IDLE;
                        done_c  = 1'b1;
                    end
                end else begin
                    frame_tready_c = out_free_c;
                    if (out_free_c && s_axis_frame_tvalid) begin
                        m_tdata_d  = masked_c;
                        m_tvalid_d = 1'b1;
                        m_tlast_d  = last_c;
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (last_c && drain_words_q != '0) begin
                            word_cnt_d = '0;
                            state_d    = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (word_cnt_q == drain_words_q) begin
                    if (out_free_c) begin
                        state_d = ST_IDLE;
                        done_c  = 1'b1;
                    end
                end else begin
                    frame_tready_c = 1'b1;
                    if (s_axis_frame_tvalid) word_cnt_d = word_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt_q    <= '0;
            matched_q     <= '0;
            size_q        <= '0;
            ts_q          <= '0;
            out_words_q   <= '0;
            drain_words_q <= '0;
            trunc_q       <= 1'b0;
            eff_lo_q      <= '0;
            m_tdata_q     <= '0;
            m_tlast_q     <= 1'b0;
            m_tvalid_q    <= 1'b0;
        end else begin
            word_cnt_q    <= word_cnt_d;
            matched_q     <= matched_d;
            size_q        <= size_d;
            ts_q          <= ts_d;
            out_words_q   <= out_words_d;
            drain_words_q <= drain_words_d;
            trunc_q       <= trunc_d;
            eff_lo_q      <= eff_lo_d;
            m_tdata_q     <= m_tdata_d;
            m_tlast_q     <= m_tlast_d;
            m_tvalid_q    <= m_tvalid_d;
        end
    end

    // Saturating message counters; srst wins over a same-cycle completion.
    always_ff @(posedge clk) begin
        if (!rst_n || srst) begin
            logged_q    <= '0;
            trunc_cnt_q <= '0;
        end else if (done_c) begin
            if (logged_q != '1)               logged_q    <= logged_q + 32'd1;
            if (trunc_q && trunc_cnt_q != '1) trunc_cnt_q <= trunc_cnt_q + 32'd1;
        end
    end

    assign s_axis_ctl_tready   = ctl_tready_c;
    assign s_axis_frame_tready = frame_tready_c;
    assign m_axis_log_tdata    = m_tdata_q;
    assign m_axis_log_tlast    = m_tlast_q;
    assign m_axis_log_tvalid   = m_tvalid_q;
    assign frames_logged       = logged_q;
    assign frames_truncated    = trunc_cnt_q;

endmodule
